riscv_misaligned_split: RTL and testbench

- Services misaligned data accesses instead of only flagging them.
- Sits between the CPU data-memory port and the data BIU.
- Accepts one byte/halfword/word/dword request and issues one or two naturally aligned full-lane memory transactions with byte enables.
- For reads, merges the returned data and right-justifies it; for writes, splits and lane-shifts the store data.

---
 rtl/riscv_misaligned_split.sv | 251 +++++++++++++++++++++++++
 tb/tb_riscv_misaligned_split.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_misaligned_split.sv
// riscv_misaligned_split
//   Sits between the CPU data port and the data BIU. It turns one byte, halfword,
//   word or dword access into one or two naturally aligned full-lane memory beats.
//   On loads it merges the returned lanes, right-justifies them and zero-extends
//   them. On stores it lane-shifts the data and splits it across the two beats.
//
//   Optional feature macro: RV_MISALIGNED_SPLIT_EN
//     defined   : accesses that straddle a lane boundary are issued as two beats.
//     undefined : such accesses complete at once with err_o=1 and no memory
//                 traffic. The BEAT2 path is not built.
//
//   Handshakes:
//     CPU side : req_i is sampled only while busy_o=0. Completion is a one-cycle
//                ack_o pulse, with err_o and q_o valid in that cycle. q_o keeps
//                its value until the next ack_o.
//     Mem side : a beat is offered by raising mem_req_o. mem_we_o, mem_adr_o,
//                mem_be_o and mem_d_o stay stable until mem_ack_i is seen high on a
//                rising clk_i edge. mem_req_o drops in the next cycle. mem_ack_i
//                is ignored while mem_req_o is low.
//
//   Size encoding: 0=BYTE, 1=HWORD, 2=WORD, 3=DWORD (access length is 1<<size).

module riscv_misaligned_split #(
   parameter int  XLEN       = 32,
   parameter type biu_size_t = logic [1:0]
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [XLEN-1:0]   adr_i,
   input  biu_size_t         size_i,
   input  logic [XLEN-1:0]   d_i,
   output logic              busy_o,
   output logic              ack_o,
   output logic              err_o,
   output logic [XLEN-1:0]   q_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN-1:0]   mem_adr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_d_o,
   input  logic              mem_ack_i,
   input  logic              mem_err_i,
   input  logic [XLEN-1:0]   mem_q_i
);

   localparam int NL = XLEN / 8;        // byte lanes per beat
   localparam int OW = $clog2(NL);      // width of the lane offset

   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state_q;

   // capture-time decode of the incoming request
   logic [1:0]      size_w;
   logic [OW-1:0]   off_w;
   logic [3:0]      nbytes_w;
   logic [NL-1:0]   ones_w;
   logic            split_w;
   logic            illegal_w;
   logic [XLEN-1:0] aligned_w;
   logic [NL-1:0]   be_lo_w;
   logic [XLEN-1:0] d_lo_w;

   // transaction context
   logic            we_q;
   logic            err_q;
   logic [OW-1:0]   off_q;
   logic [NL-1:0]   ones_q;
   logic [XLEN-1:0] res_q;

   // read merge
   logic [XLEN-1:0] b1_w;
   logic [XLEN-1:0] b2_w;
   logic [XLEN-1:0] mask_w;
   logic [XLEN-1:0] merged_w;

   logic            beat_done_w;

   assign size_w      = size_i;
   assign beat_done_w = mem_req_o & mem_ack_i;

   // Decode offset, length, lane layout and split/illegal status of the request
   always_comb begin
      off_w     = adr_i[OW-1:0];
      nbytes_w  = 4'd1 << size_w;
      ones_w    = '0;
      for (int i = 0; i < NL; i++) begin
         ones_w[i] = (i < int'(nbytes_w));
      end
      illegal_w = (XLEN == 32) && (size_w == SZ_DWORD);
      split_w   = (int'(off_w) + int'(nbytes_w)) > NL;
      aligned_w = {adr_i[XLEN-1:OW], {OW{1'b0}}};
      be_lo_w   = ones_w << off_w;
      d_lo_w    = d_i << {off_w, 3'b000};
   end

   // Right-justify the lanes of one or two beats and clear bytes past the length
   always_comb begin
      mask_w = '0;
      for (int i = 0; i < NL; i++) begin
         mask_w[8*i +: 8] = {8{ones_q[i]}};
      end
      merged_w = XLEN'({b2_w, b1_w} >> {off_q, 3'b000}) & mask_w;
   end

`ifdef RV_MISALIGNED_SPLIT_EN
   logic            split_q;
   logic [XLEN-1:0] adr2_q;
   logic [XLEN-1:0] d2_q;
   logic [XLEN-1:0] beat1_q;
   logic [NL-1:0]   be2_q;

   // Hold the second-beat lane layout from capture, and the first-beat read data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         split_q <= 1'b0;
         adr2_q  <= '0;
         d2_q    <= '0;
         be2_q   <= '0;
         beat1_q <= '0;
      end else begin
         if (state_q == IDLE && req_i) begin
            split_q <= split_w;
            adr2_q  <= aligned_w + XLEN'(NL);
            be2_q   <= ones_w >> (NL - int'(off_w));
            d2_q    <= d_i >> (XLEN - 8 * int'(off_w));
         end
         if (state_q == BEAT1 && beat_done_w) begin
            beat1_q <= mem_q_i;
         end
      end
   end

   assign b1_w = split_q ? beat1_q : mem_q_i;
   assign b2_w = split_q ? mem_q_i : '0;
`else
   assign b1_w = mem_q_i;
   assign b2_w = '0;
`endif

   // Transaction FSM: capture, one or two memory beats, then a one-cycle response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         busy_o    <= 1'b0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         q_o       <= '0;
         mem_req_o <= 1'b0;
         mem_we_o  <= 1'b0;
         mem_adr_o <= '0;
         mem_be_o  <= '0;
         mem_d_o   <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         off_q     <= '0;
         ones_q    <= '0;
         res_q     <= '0;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  busy_o <= 1'b1;
                  we_q   <= we_i;
                  off_q  <= off_w;
                  ones_q <= ones_w;
                  err_q  <= 1'b0;
                  res_q  <= '0;
`ifdef RV_MISALIGNED_SPLIT_EN
                  if (illegal_w) begin
`else
                  if (illegal_w || split_w) begin
`endif
                     err_q   <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     state_q   <= BEAT1;
                     mem_req_o <= 1'b1;
                     mem_we_o  <= we_i;
                     mem_adr_o <= aligned_w;
                     mem_be_o  <= be_lo_w;
                     mem_d_o   <= d_lo_w;
                  end
               end
            end
            BEAT1: begin
               if (beat_done_w) begin
                  mem_req_o <= 1'b0;
                  if (mem_err_i) begin
                     err_q    <= 1'b1;
                     mem_we_o <= 1'b0;
                     state_q  <= RESP;
                  end
`ifdef RV_MISALIGNED_SPLIT_EN
                  else if (split_q) begin
                     state_q   <= BEAT2;
                     mem_adr_o <= adr2_q;
                     mem_be_o  <= be2_q;
                     mem_d_o   <= d2_q;
                  end
`endif
                  else begin
                     res_q    <= merged_w;
                     mem_we_o <= 1'b0;
                     state_q  <= RESP;
                  end
               end
            end
`ifdef RV_MISALIGNED_SPLIT_EN
            BEAT2: begin
               // First cycle here is the idle gap after beat 1; then offer beat 2
               if (!mem_req_o) begin
                  mem_req_o <= 1'b1;
               end else if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  state_q   <= RESP;
                  if (mem_err_i) begin
                     err_q <= 1'b1;
                  end else begin
                     res_q <= merged_w;
                  end
               end
            end
`endif
            RESP: begin
               ack_o   <= 1'b1;
               err_o   <= err_q;
               q_o     <= (err_q || we_q) ? '0 : res_q;
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_misaligned_split.sv
// Bench for riscv_misaligned_split (XLEN=32): a table of directed load/store
// vectors with hand-computed beats and results, plus hand-written sequences for
// held req_i, a stray mem_ack_i in the inter-beat gap, a stray mem_ack_i while
// idle, and reset in the middle of a transaction.

module tb_riscv_misaligned_split;

   localparam int XLEN = 32;
`ifdef RV_MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req_i;
   logic              we_i;
   logic [XLEN-1:0]   adr_i;
   logic [1:0]        size_i;
   logic [XLEN-1:0]   d_i;
   logic              busy_o;
   logic              ack_o;
   logic              err_o;
   logic [XLEN-1:0]   q_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [XLEN-1:0]   mem_adr_o;
   logic [XLEN/8-1:0] mem_be_o;
   logic [XLEN-1:0]   mem_d_o;
   logic              mem_ack_i;
   logic              mem_err_i;
   logic [XLEN-1:0]   mem_q_i;

   int total = 0;
   int bad   = 0;

   riscv_misaligned_split #(.XLEN(XLEN)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .we_i      (we_i),
      .adr_i     (adr_i),
      .size_i    (size_i),
      .d_i       (d_i),
      .busy_o    (busy_o),
      .ack_o     (ack_o),
      .err_o     (err_o),
      .q_o       (q_o),
      .mem_req_o (mem_req_o),
      .mem_we_o  (mem_we_o),
      .mem_adr_o (mem_adr_o),
      .mem_be_o  (mem_be_o),
      .mem_d_o   (mem_d_o),
      .mem_ack_i (mem_ack_i),
      .mem_err_i (mem_err_i),
      .mem_q_i   (mem_q_i)
   );

   // clock
   always #5 clk_i = ~clk_i;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [1:0]  size;
      logic [31:0] d;
      logic        split;
      logic        illegal;
      logic        err1;
      logic        err2;
      logic [31:0] q1;
      logic [31:0] q2;
      logic [31:0] adr1;
      logic [3:0]  be1;
      logic [31:0] d1;
      logic [31:0] adr2;
      logic [3:0]  be2;
      logic [31:0] d2;
      logic [31:0] exp_q;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present one request, act as the memory for every beat, check beats and response
   task automatic run_vec(input int id, input vec_t v, input bit keep_req, input bit linger);
      bit          no_traffic;
      int          exp_beats;
      bit          exp_err;
      logic [31:0] eq;
      int          beats;
      bit          got_ack;
      bit          linger_pend;
      logic [31:0] s_adr;
      logic [31:0] s_d;
      logic [3:0]  s_be;
      no_traffic = v.illegal || (v.split && !SPLIT_EN);
      exp_beats  = no_traffic ? 0 : ((v.split && !v.err1) ? 2 : 1);
      exp_err    = no_traffic || v.err1 || (v.split && v.err2);
      eq         = (exp_err || v.we) ? 32'h0 : v.exp_q;

      @(negedge clk_i);
      req_i  = 1'b1;
      we_i   = v.we;
      adr_i  = v.adr;
      size_i = v.size;
      d_i    = v.d;
      @(negedge clk_i);
      if (keep_req) adr_i = 32'h0000_0500;
      else req_i = 1'b0;
      check($sformatf("v%0d busy_rise", id), busy_o, 1);

      beats       = 0;
      got_ack     = 1'b0;
      linger_pend = linger;
      for (int cyc = 0; cyc < 40 && !got_ack; cyc++) begin
         if (cyc > 0) @(negedge clk_i);
         if (ack_o) begin
            got_ack = 1'b1;
            req_i   = 1'b0;
            check($sformatf("v%0d err", id), err_o, exp_err);
            check($sformatf("v%0d q", id), q_o, eq);
            check($sformatf("v%0d busy_fall", id), busy_o, 0);
            if (no_traffic) check($sformatf("v%0d ack_latency", id), cyc, 1);
         end else if (mem_ack_i) begin
            if (linger_pend) begin
               // stray ack with error in the gap before beat 2 must be ignored
               linger_pend = 1'b0;
               mem_err_i   = 1'b1;
               mem_q_i     = 32'hDEAD_BEEF;
            end else begin
               mem_ack_i = 1'b0;
               mem_err_i = 1'b0;
               mem_q_i   = 32'h0;
            end
         end else if (mem_req_o) begin
            beats++;
            check($sformatf("v%0d we%0d", id, beats), mem_we_o, v.we);
            check($sformatf("v%0d adr%0d", id, beats), mem_adr_o, (beats == 1) ? v.adr1 : v.adr2);
            check($sformatf("v%0d be%0d", id, beats), mem_be_o, (beats == 1) ? v.be1 : v.be2);
            if (v.we) check($sformatf("v%0d d%0d", id, beats), mem_d_o, (beats == 1) ? v.d1 : v.d2);
            s_adr = mem_adr_o;
            s_be  = mem_be_o;
            s_d   = mem_d_o;
            @(negedge clk_i);
            check($sformatf("v%0d hold%0d", id, beats), {mem_req_o, mem_adr_o, mem_be_o, mem_d_o},
                  {1'b1, s_adr, s_be, s_d});
            mem_ack_i = 1'b1;
            mem_err_i = (beats == 1) ? v.err1 : v.err2;
            mem_q_i   = (beats == 1) ? v.q1 : v.q2;
         end
      end
      check($sformatf("v%0d ack_seen", id), got_ack, 1);
      check($sformatf("v%0d beats", id), beats, exp_beats);
      req_i     = 1'b0;
      mem_ack_i = 1'b0;
      mem_err_i = 1'b0;
      mem_q_i   = 32'h0;
      @(negedge clk_i);
      check($sformatf("v%0d ack_pulse", id), ack_o, 0);
      check($sformatf("v%0d q_hold", id), q_o, eq);
      check($sformatf("v%0d idle_after", id), {busy_o, mem_req_o}, 2'b00);
   endtask

   initial begin
      bit any_ack;

      //                we  adr           sz d             spl ill e1 e2 q1            q2            adr1          be1   d1            adr2          be2   d2            exp_q
      vecs[0]  = '{1'b0, 32'h0000_0100, 2, 32'h0,        0, 0, 0, 0, 32'h1122_3344, 32'h0,        32'h0000_0100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'h1122_3344};
      vecs[1]  = '{1'b0, 32'h0000_0103, 2, 32'h0,        1, 0, 0, 0, 32'hDDCC_BBAA, 32'h4433_2211, 32'h0000_0100, 4'h8, 32'h0,        32'h0000_0104, 4'h7, 32'h0,        32'h3322_11DD};
      vecs[2]  = '{1'b1, 32'h0000_00FF, 1, 32'h0000_BEEF, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0000_00FC, 4'h8, 32'hEF00_0000, 32'h0000_0100, 4'h1, 32'h0000_00BE, 32'h0};
      vecs[3]  = '{1'b0, 32'h0000_0102, 2, 32'h0,        1, 0, 1, 0, 32'h5555_5555, 32'h0,        32'h0000_0100, 4'hC, 32'h0,        32'h0000_0104, 4'h3, 32'h0,        32'h0};
      vecs[4]  = '{1'b0, 32'hFFFF_FFFE, 2, 32'h0,        1, 0, 0, 0, 32'h2211_7777, 32'h9988_4433, 32'hFFFF_FFFC, 4'hC, 32'h0,        32'h0000_0000, 4'h3, 32'h0,        32'h4433_2211};
      vecs[5]  = '{1'b0, 32'h0000_0201, 0, 32'h0,        0, 0, 0, 0, 32'hA1B2_C3D4, 32'h0,        32'h0000_0200, 4'h2, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_00C3};
      vecs[6]  = '{1'b0, 32'h0000_0202, 1, 32'h0,        0, 0, 0, 0, 32'h5566_7788, 32'h0,        32'h0000_0200, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_5566};
      vecs[7]  = '{1'b1, 32'h0000_0003, 0, 32'hFFFF_FF5A, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 4'h8, 32'h5A00_0000, 32'h0,        4'h0, 32'h0,        32'h0};
      vecs[8]  = '{1'b1, 32'h0000_0201, 2, 32'h1234_5678, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0200, 4'hE, 32'h3456_7800, 32'h0000_0204, 4'h1, 32'h0000_0012, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_0003, 1, 32'h0,        1, 0, 0, 0, 32'hAB00_0000, 32'hFFFF_FFCD, 32'h0000_0000, 4'h8, 32'h0,        32'h0000_0004, 4'h1, 32'h0,        32'h0000_CDAB};
      vecs[10] = '{1'b0, 32'h0000_0101, 2, 32'h0,        1, 0, 0, 1, 32'h1111_1111, 32'h2222_2222, 32'h0000_0100, 4'hE, 32'h0,        32'h0000_0104, 4'h1, 32'h0,        32'h0};
      vecs[11] = '{1'b0, 32'h0000_0100, 3, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 32'h0000_0002, 1, 32'h0,        0, 0, 0, 0, 32'hCAFE_BABE, 32'h0,        32'h0000_0000, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_CAFE};
      vecs[13] = '{1'b1, 32'h0000_0104, 2, 32'hA5A5_0F0F, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0104, 4'hF, 32'hA5A5_0F0F, 32'h0,        4'h0, 32'h0,        32'h0};

      // reset
      rst_ni    = 1'b0;
      req_i     = 1'b0;
      we_i      = 1'b0;
      adr_i     = '0;
      size_i    = '0;
      d_i       = '0;
      mem_ack_i = 1'b0;
      mem_err_i = 1'b0;
      mem_q_i   = '0;
      repeat (3) @(negedge clk_i);
      check("rst ctrl", {busy_o, ack_o, err_o, mem_req_o, mem_we_o}, 5'b0);
      check("rst adr", mem_adr_o, 0);
      check("rst be", mem_be_o, 0);
      check("rst d", mem_d_o, 0);
      check("rst q", q_o, 0);
      rst_ni = 1'b1;

      // table
      for (int i = 0; i < 14; i++) begin
         run_vec(i, vecs[i], 1'b0, 1'b0);
      end

      // req_i held high (with a new address) during busy is ignored
      run_vec(20, vecs[0], 1'b1, 1'b0);

      // stray erroring ack in the gap between beats is ignored
      run_vec(21, vecs[1], 1'b0, 1'b1);

      // mem_ack_i while idle is ignored
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      mem_err_i = 1'b1;
      any_ack   = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         any_ack = any_ack | ack_o | busy_o | mem_req_o;
      end
      mem_ack_i = 1'b0;
      mem_err_i = 1'b0;
      check("idle_stray_ack", any_ack, 0);
      run_vec(22, vecs[6], 1'b0, 1'b0);

      // reset during the last beat (BEAT2 when splitting is built, else BEAT1)
      @(negedge clk_i);
      req_i  = 1'b1;
      we_i   = 1'b0;
      adr_i  = SPLIT_EN ? 32'h0000_0103 : 32'h0000_0100;
      size_i = 2'd2;
      d_i    = '0;
      @(negedge clk_i);
      req_i = 1'b0;
      for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk_i);
      if (SPLIT_EN) begin
         mem_ack_i = 1'b1;
         mem_q_i   = 32'h7777_7777;
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         mem_q_i   = '0;
         for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk_i);
      end
      check("rst_mid setup_req", mem_req_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_mid req", mem_req_o, 0);
      check("rst_mid busy", busy_o, 0);
      check("rst_mid be_adr", {mem_be_o, mem_adr_o}, 0);
      check("rst_mid q", q_o, 0);
      any_ack = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         any_ack = any_ack | ack_o;
      end
      check("rst_mid no_ack", any_ack, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("rst_mid after", {busy_o, ack_o, mem_req_o}, 3'b000);
      run_vec(30, '{1'b0, 32'h0000_0200, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_56AB, 32'h0,
                     32'h0000_0200, 4'h1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_00AB}, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
